// File: rtl/issue_queue_age_scheduler_if.sv
// Handshake bundle between an age-ordered issue queue, its dispatch stage and its scheduler.
// The scheduler connects to the slave modport; the queue/dispatch side connects to the master.
interface issue_queue_age_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int IW = $clog2(DEPTH);

  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [DEPTH-1:0] rs_queue_valid_bits;
  logic [DEPTH-1:0] incoming_valid_bits;
  logic [DEPTH-1:0] rs_ready_bits;
  logic             fu_ready;
  logic             rs_station_wen;
  logic [IW-1:0]    rs_station_waddr;
  logic             rs_station_complete;
  logic [IW-1:0]    rs_station_raddr;
  logic             issue_valid;
  logic [IW:0]      occupancy;

  modport master (
    output dispatch_valid, rs_queue_valid_bits, incoming_valid_bits, rs_ready_bits, fu_ready,
    input  dispatch_ready, rs_station_wen, rs_station_waddr, rs_station_complete,
           rs_station_raddr, issue_valid, occupancy
  );

  modport slave (
    input  dispatch_valid, rs_queue_valid_bits, incoming_valid_bits, rs_ready_bits, fu_ready,
    output dispatch_ready, rs_station_wen, rs_station_waddr, rs_station_complete,
           rs_station_raddr, issue_valid, occupancy
  );
endinterface

// File: rtl/issue_queue_age_scheduler.sv
// Slot allocator, age matrix and oldest-ready select for one age-ordered issue queue,
// with an issue throttle for non-pipelined functional units and an occupancy report.
module issue_queue_age_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int FU_BUSY_CYCLES = 1
) (
  input logic                        clk,
  input logic                        rst,
  issue_queue_age_scheduler_if.slave bus
);
  localparam int IW = $clog2(QUEUE_DEPTH);
  localparam int BW = (FU_BUSY_CYCLES > 1) ? $clog2(FU_BUSY_CYCLES) : 1;
  localparam logic [BW-1:0] BUSY_RELOAD = BW'(FU_BUSY_CYCLES - 1);

  logic [QUEUE_DEPTH-1:0] older [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] cand;
  logic [BW-1:0]          busy_cnt;
  logic [IW:0]            occ;
  logic [IW-1:0]          waddr;
  logic [IW-1:0]          raddr;
  logic                   free_found;
  logic                   blocked;
  logic                   any_ready;
  logic                   issue;
  logic                   wen;

  // Lowest free slot, judged on the current valid bits so a slot freed this cycle waits a cycle.
  always_comb begin
    free_found = 1'b0;
    waddr      = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!free_found && !bus.rs_queue_valid_bits[i]) begin
        free_found = 1'b1;
        waddr      = IW'(i);
      end
    end
  end

  always_comb begin
    cand    = '0;
    raddr   = '0;
    blocked = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      blocked = 1'b0;
      for (int k = 0; k < QUEUE_DEPTH; k++)
        blocked = blocked | (bus.rs_ready_bits[k] & older[k][i]);
      cand[i] = bus.rs_ready_bits[i] & ~blocked;
    end
    for (int i = 0; i < QUEUE_DEPTH; i++)
      if (cand[i]) raddr = IW'(i);
  end

  assign any_ready = |bus.rs_ready_bits;
  assign issue     = rst & any_ready & bus.fu_ready & (busy_cnt == '0);
  assign wen       = rst & bus.dispatch_valid & free_found;

  assign bus.dispatch_ready      = rst & free_found;
  assign bus.rs_station_wen      = wen;
  assign bus.rs_station_waddr    = rst ? waddr : '0;
  assign bus.rs_station_complete = issue;
  assign bus.rs_station_raddr    = rst ? raddr : '0;
  assign bus.issue_valid         = issue;
  assign bus.occupancy           = occ;

  // A new entry is younger than every survivor; departing slots lose their row and column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        for (int j = 0; j < QUEUE_DEPTH; j++) begin
          if (i == j)
            older[i][j] <= 1'b0;
          else if (wen && waddr == IW'(i))
            older[i][j] <= 1'b0;
          else if (wen && waddr == IW'(j))
            older[i][j] <= bus.incoming_valid_bits[i];
          else if (!bus.incoming_valid_bits[i] || !bus.incoming_valid_bits[j])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
      occ      <= '0;
    end else begin
      if (issue)
        busy_cnt <= BUSY_RELOAD;
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
      occ <= (IW+1)'($countones(bus.incoming_valid_bits));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (any_ready) assert ($onehot(cand));
      for (int i = 0; i < QUEUE_DEPTH; i++)
        for (int j = 0; j < QUEUE_DEPTH; j++)
          assert (!(older[i][j] && older[j][i]));
    end
  end
endmodule

// File: tb/tb_issue_queue_age_scheduler.sv
// Bench for issue_queue_age_scheduler: the queue is modelled as a valid vector plus an
// oldest-first list of slots, and every scheduler output is predicted from that list.
module tb_issue_queue_age_scheduler;
  localparam int D    = 4;
  localparam int BUSY = 4;

  logic clk;
  logic rst;

  issue_queue_age_scheduler_if #(.DEPTH(D)) bus ();

  issue_queue_age_scheduler #(.QUEUE_DEPTH(D), .FU_BUSY_CYCLES(BUSY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [D-1:0] m_valid;
  int           m_age[$];
  int           m_busy;
  int           m_occ;

  logic       exp_dr, exp_wen, exp_issue;
  logic [1:0] exp_waddr, exp_raddr;
  int         exp_occ;
  logic       obs_dr, obs_wen, obs_cmp, obs_issue;
  logic [1:0] obs_waddr, obs_raddr;
  logic [2:0] obs_occ;

  task automatic model_clear();
    m_valid = '0;
    m_age.delete();
    m_busy = 0;
    m_occ  = 0;
  endtask

  task automatic drive_idle();
    bus.dispatch_valid      = 1'b0;
    bus.rs_queue_valid_bits = '0;
    bus.incoming_valid_bits = '0;
    bus.rs_ready_bits       = '0;
    bus.fu_ready            = 1'b0;
  endtask

  // One clock of queue activity; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic dv, input logic [D-1:0] rdy, input logic fu,
                       input logic [D-1:0] kill);
    logic [D-1:0] rb;
    logic [D-1:0] inc;
    logic         found;
    int           nq[$];
    rb = rdy & m_valid & ~kill;
    bus.dispatch_valid      = dv;
    bus.rs_queue_valid_bits = m_valid;
    bus.rs_ready_bits       = rb;
    bus.fu_ready            = fu;
    bus.incoming_valid_bits = m_valid & ~kill;

    exp_dr    = 1'b0;
    exp_waddr = '0;
    for (int i = D - 1; i >= 0; i--)
      if (!m_valid[i]) begin
        exp_dr    = 1'b1;
        exp_waddr = 2'(i);
      end
    exp_wen   = dv & exp_dr;
    exp_issue = (rb != '0) && fu && (m_busy == 0);
    exp_raddr = '0;
    found     = 1'b0;
    foreach (m_age[k])
      if (!found && rb[m_age[k]]) begin
        exp_raddr = 2'(m_age[k]);
        found     = 1'b1;
      end
    exp_occ = m_occ;

    #1;
    obs_dr    = bus.dispatch_ready;
    obs_wen   = bus.rs_station_wen;
    obs_waddr = bus.rs_station_waddr;
    obs_cmp   = bus.rs_station_complete;
    obs_issue = bus.issue_valid;
    obs_raddr = bus.rs_station_raddr;
    obs_occ   = bus.occupancy;

    inc = m_valid & ~kill;
    if (exp_issue) inc[exp_raddr] = 1'b0;
    if (exp_wen)   inc[exp_waddr] = 1'b1;
    bus.incoming_valid_bits = inc;

    @(posedge clk);
    foreach (m_age[k])
      if (inc[m_age[k]]) nq.push_back(m_age[k]);
    if (exp_wen) nq.push_back(int'(exp_waddr));
    m_age   = nq;
    m_valid = inc;
    m_occ   = $countones(inc);
    if (exp_issue)       m_busy = BUSY - 1;
    else if (m_busy > 0) m_busy = m_busy - 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.dispatch_valid      = 1'b1;
    bus.rs_queue_valid_bits = 4'b0001;
    bus.incoming_valid_bits = 4'b0011;
    bus.rs_ready_bits       = 4'b0001;
    bus.fu_ready            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.dispatch_ready !== 1'b0) begin n_bad++; $display("FAIL reset dispatch_ready got %b want 0", bus.dispatch_ready); end
    n_cmp++; if (bus.rs_station_wen !== 1'b0) begin n_bad++; $display("FAIL reset wen got %b want 0", bus.rs_station_wen); end
    n_cmp++; if (bus.rs_station_waddr !== 2'd0) begin n_bad++; $display("FAIL reset waddr got %0d want 0", bus.rs_station_waddr); end
    n_cmp++; if (bus.rs_station_complete !== 1'b0) begin n_bad++; $display("FAIL reset complete got %b want 0", bus.rs_station_complete); end
    n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset issue_valid got %b want 0", bus.issue_valid); end
    n_cmp++; if (bus.occupancy !== 3'd0) begin n_bad++; $display("FAIL reset occupancy got %0d want 0", bus.occupancy); end
    drive_idle();
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dispatch_order();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
      n_cmp++; if (obs_wen !== 1'b1) begin n_bad++; $display("FAIL order wen[%0d] got %b want 1", i, obs_wen); end
      n_cmp++; if (obs_waddr !== 2'(i)) begin n_bad++; $display("FAIL order waddr[%0d] got %0d want %0d", i, obs_waddr, i); end
    end
    cycle(1'b0, 4'b0110, 1'b0, 4'b0000);
    n_cmp++; if (obs_occ !== 3'd3) begin n_bad++; $display("FAIL order occupancy got %0d want 3", obs_occ); end
    n_cmp++; if (obs_raddr !== 2'd1) begin n_bad++; $display("FAIL order raddr_b_vs_c got %0d want 1", obs_raddr); end
    cycle(1'b0, 4'b0111, 1'b0, 4'b0000);
    n_cmp++; if (obs_raddr !== 2'd0) begin n_bad++; $display("FAIL order raddr_all got %0d want 0", obs_raddr); end
    n_cmp++; if (obs_issue !== 1'b0) begin n_bad++; $display("FAIL order issue_without_fu got %b want 0", obs_issue); end
  endtask

  task automatic test_kill_and_age();
    cycle(1'b1, 4'b0000, 1'b0, 4'b0010);
    n_cmp++; if (obs_waddr !== 2'd3 || obs_wen !== 1'b1) begin n_bad++; $display("FAIL kill_alloc waddr/wen got %0d/%b want 3/1", obs_waddr, obs_wen); end
    cycle(1'b0, 4'b1001, 1'b0, 4'b0000);
    n_cmp++; if (obs_raddr !== 2'd0) begin n_bad++; $display("FAIL kill_age older03 raddr got %0d want 0", obs_raddr); end
    cycle(1'b0, 4'b1100, 1'b0, 4'b0000);
    n_cmp++; if (obs_raddr !== 2'd2) begin n_bad++; $display("FAIL kill_age older23 raddr got %0d want 2", obs_raddr); end
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    n_cmp++; if (obs_waddr !== 2'd1) begin n_bad++; $display("FAIL kill_realloc waddr got %0d want 1", obs_waddr); end
    cycle(1'b0, 4'b1010, 1'b0, 4'b0000);
    n_cmp++; if (obs_raddr !== 2'd3) begin n_bad++; $display("FAIL kill_age older31 raddr got %0d want 3", obs_raddr); end
    cycle(1'b0, 4'b0110, 1'b0, 4'b0000);
    n_cmp++; if (obs_raddr !== 2'd2) begin n_bad++; $display("FAIL age_sel 0110 raddr got %0d want 2", obs_raddr); end
  endtask

  task automatic test_full_issue();
    cycle(1'b1, 4'b0001, 1'b1, 4'b0000);
    n_cmp++; if (obs_dr !== 1'b0) begin n_bad++; $display("FAIL full dispatch_ready got %b want 0", obs_dr); end
    n_cmp++; if (obs_wen !== 1'b0) begin n_bad++; $display("FAIL full wen got %b want 0", obs_wen); end
    n_cmp++; if (obs_cmp !== 1'b1 || obs_raddr !== 2'd0) begin n_bad++; $display("FAIL full issue complete/raddr got %b/%0d want 1/0", obs_cmp, obs_raddr); end
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    n_cmp++; if (obs_wen !== 1'b1 || obs_waddr !== 2'd0) begin n_bad++; $display("FAIL full reuse wen/waddr got %b/%0d want 1/0", obs_wen, obs_waddr); end
    cycle(1'b0, 4'b1111, 1'b0, 4'b0000);
    n_cmp++; if (obs_raddr !== 2'd2) begin n_bad++; $display("FAIL full newest_is_youngest raddr got %0d want 2", obs_raddr); end
  endtask

  task automatic test_fu_throttle();
    logic want;
    repeat (4) begin
      cycle(1'b0, 4'b0000, 1'b1, 4'b0000);
      n_cmp++; if (obs_issue !== 1'b0) begin n_bad++; $display("FAIL throttle idle issue got %b want 0", obs_issue); end
    end
    for (int k = 0; k < 9; k++) begin
      want = (k % BUSY) == 0;
      cycle(1'b1, 4'b0011, 1'b1, 4'b0000);
      n_cmp++; if (obs_cmp !== want) begin n_bad++; $display("FAIL throttle complete[t+%0d] got %b want %b", k, obs_cmp, want); end
      n_cmp++; if (obs_issue !== want) begin n_bad++; $display("FAIL throttle issue_valid[t+%0d] got %b want %b", k, obs_issue, want); end
    end
  endtask

  task automatic test_random();
    logic [D-1:0] kill;
    for (int n = 0; n < 300; n++) begin
      kill = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      cycle(1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), kill);
      n_cmp++; if (obs_dr !== exp_dr) begin n_bad++; $display("FAIL rand[%0d] dispatch_ready got %b want %b", n, obs_dr, exp_dr); end
      n_cmp++; if (obs_wen !== exp_wen) begin n_bad++; $display("FAIL rand[%0d] wen got %b want %b", n, obs_wen, exp_wen); end
      n_cmp++; if (obs_waddr !== exp_waddr) begin n_bad++; $display("FAIL rand[%0d] waddr got %0d want %0d", n, obs_waddr, exp_waddr); end
      n_cmp++; if (obs_cmp !== exp_issue) begin n_bad++; $display("FAIL rand[%0d] complete got %b want %b", n, obs_cmp, exp_issue); end
      n_cmp++; if (obs_issue !== exp_issue) begin n_bad++; $display("FAIL rand[%0d] issue_valid got %b want %b", n, obs_issue, exp_issue); end
      n_cmp++; if (obs_raddr !== exp_raddr) begin n_bad++; $display("FAIL rand[%0d] raddr got %0d want %0d", n, obs_raddr, exp_raddr); end
      n_cmp++; if (obs_occ !== 3'(exp_occ)) begin n_bad++; $display("FAIL rand[%0d] occupancy got %0d want %0d", n, obs_occ, exp_occ); end
    end
  endtask

  task automatic test_mid_reset();
    for (int n = 0; n < 4; n++)
      if ($countones(m_valid) < 3) cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    bus.dispatch_valid      = 1'b1;
    bus.rs_queue_valid_bits = m_valid;
    bus.incoming_valid_bits = m_valid;
    bus.rs_ready_bits       = m_valid;
    bus.fu_ready            = 1'b1;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== 3'd0) begin n_bad++; $display("FAIL midrst occupancy got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.rs_station_complete !== 1'b0) begin n_bad++; $display("FAIL midrst complete got %b want 0", bus.rs_station_complete); end
    n_cmp++; if (bus.dispatch_ready !== 1'b0 || bus.rs_station_wen !== 1'b0) begin n_bad++; $display("FAIL midrst ready/wen got %b/%b want 0/0", bus.dispatch_ready, bus.rs_station_wen); end
    n_cmp++; if (bus.rs_station_raddr !== 2'd0) begin n_bad++; $display("FAIL midrst raddr got %0d want 0", bus.rs_station_raddr); end
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (bus.issue_valid !== 1'b0) begin n_bad++; $display("FAIL midrst held issue_valid[%0d] got %b want 0", n, bus.issue_valid); end
      n_cmp++; if (bus.occupancy !== 3'd0) begin n_bad++; $display("FAIL midrst held occupancy[%0d] got %0d want 0", n, bus.occupancy); end
    end
    drive_idle();
    model_clear();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    n_cmp++; if (obs_wen !== 1'b1 || obs_waddr !== 2'd0) begin n_bad++; $display("FAIL postrst alloc wen/waddr got %b/%0d want 1/0", obs_wen, obs_waddr); end
    cycle(1'b1, 4'b0001, 1'b1, 4'b0000);
    n_cmp++; if (obs_cmp !== 1'b1 || obs_raddr !== 2'd0) begin n_bad++; $display("FAIL postrst issue complete/raddr got %b/%0d want 1/0", obs_cmp, obs_raddr); end
    n_cmp++; if (obs_occ !== 3'd1 || obs_waddr !== 2'd1) begin n_bad++; $display("FAIL postrst occ/waddr got %0d/%0d want 1/1", obs_occ, obs_waddr); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_dispatch_order();
    test_kill_and_age();
    test_full_issue();
    test_fu_throttle();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
